unsaved_cpu_div_cell: RTL and testbench
=======================================

Name: unsaved_cpu_div_cell

Overview:
- Iterative radix-2 restoring integer divider. It is the inverse-operation companion to the CPU's multiply cell.
- Sits in the CPU M stage and serves the div/divu instructions.
- Uses a start/done handshake: a start pulse is accepted only when idle; quotient and remainder are returned after a fixed latency.
- Signed and unsigned modes are both supported. Divide-by-zero and signed overflow results are architecturally defined.

Parameters:
- WIDTH, 32, operand/result width in bits. Must be even and ≥ 4.
- CNT_W, 6, iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset_n  input  1  asynchronous active-low reset
- M_div_src1  input  WIDTH  dividend
- M_div_src2  input  WIDTH  divisor
- M_div_signed  input  1  1 = two's-complement operands, 0 = unsigned
- M_div_start  input  1  start request; sampled only in IDLE
- M_div_busy  output  1  high from the accepting edge until done deasserts
- M_div_done  output  1  single-cycle pulse: results valid
- M_div_quotient  output  WIDTH  quotient, held until the next accepted start
- M_div_remainder  output  WIDTH  remainder, held until the next accepted start

Behaviour:
- Reset (asynchronous, any state, mid-operation included):
  - state = IDLE.
  - busy = 0, done = 0, quotient = 0, remainder = 0, counter = 0.
  - Any in-flight operation is discarded.
- States: IDLE, CALC, FIXUP, DONE.
- IDLE:
  - If start = 1 at edge E0: capture operands and mode, busy <= 1.
  - If divisor == 0: go directly to FIXUP (skip CALC).
  - Otherwise: convert operands to magnitudes (when signed), record sign_q = s1^s2 and sign_r = s1, load partial remainder = 0, counter = 0, go to CALC.
- CALC, one iteration per edge, edges E1..E32 for WIDTH = 32:
  - Shift {rem, dvd} left by 1.
  - Trial-subtract the divisor magnitude from rem, using a WIDTH+1 bit subtract.
  - If the result is non-negative, rem <= difference and shift in quotient bit 1; otherwise shift in 0.
  - counter++. Leave to FIXUP after WIDTH iterations.
- FIXUP (edge E33 for a normal op):
  - Negate quotient if signed && sign_q.
  - Negate remainder if signed && sign_r. The remainder takes the sign of the dividend (truncating division).
  - Write the output registers. done <= 1. Go to DONE.
- DONE (one cycle):
  - At the next edge: done <= 0, busy <= 0, state IDLE.
  - A start that is high during DONE is ignored.
- Latency:
  - Normal op: done high in the cycle after E33, i.e. 33 cycles after the accepting edge.
  - Divide-by-zero: done high after E1.
- Divide by zero (both modes): quotient = all ones; remainder = dividend, unmodified.
- Signed overflow (src1 = 0x80000000, src2 = 0xFFFFFFFF, signed): falls out of the algorithm as quotient = 0x80000000, remainder = 0. Must not hang or saturate.
- Start while busy: ignored, no queuing. The outputs keep their old values until the new FIXUP.
- Operand stability: operand inputs may change after E0; the block uses captured copies only.
- Back-to-back: the earliest new start is accepted in IDLE, one cycle after done.
- Arithmetic: magnitudes are held unsigned in WIDTH bits. abs(0x80000000) = 0x80000000 is correct as an unsigned value.

Test Plan:
- Unsigned 100 / 7: start at E0 → done exactly 33 cycles later; quotient 14, remainder 2; busy high E0..done cycle.
- Signed −100 / 7 → quotient 0xFFFFFFF2 (−14), remainder 0xFFFFFFFE (−2). Signed 100 / −7 → quotient −14, remainder 2.
- Divide by zero: 0x12345678 / 0, both modes → done after 1 cycle; quotient 0xFFFFFFFF, remainder 0x12345678.
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0. Unsigned 0xFFFFFFFF / 1 → quotient 0xFFFFFFFF, remainder 0.
- Start re-pulsed and operands changed at cycle 10 of an op → ignored; original result delivered; next start accepted in IDLE; back-to-back results are correct.
- reset_n low at cycle 15 of an op → busy, done and outputs go to 0 immediately; after release, a fresh 50 / 5 gives quotient 10, remainder 0.

Source files
------------

// File: rtl/unsaved_cpu_div_cell.sv
// Iterative radix-2 restoring divider (signed/unsigned) for the M-stage div/divu path.
// Latency: done pulses WIDTH+1 cycles after the accepting edge (1 cycle for divide-by-zero).
// Backpressure: start is honoured only in IDLE; starts while busy or in DONE are dropped.
module unsaved_cpu_div_cell #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] M_div_src1,
    input  logic [WIDTH-1:0] M_div_src2,
    input  logic             M_div_signed,
    input  logic             M_div_start,
    output logic             M_div_busy,
    output logic             M_div_done,
    output logic [WIDTH-1:0] M_div_quotient,
    output logic [WIDTH-1:0] M_div_remainder
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FIXUP = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   quot_out_q;
    logic [WIDTH-1:0]   rem_out_q;
    logic [CNT_W-1:0]   cnt_q;

    // Working registers: dvd_q starts as the dividend magnitude and fills up
    // with quotient bits from the right as the dividend bits shift out left.
    logic [WIDTH-1:0]   dvd_q;
    logic [WIDTH-1:0]   prem_q;
    logic [WIDTH-1:0]   dvs_q;
    logic [WIDTH-1:0]   src1_raw_q;
    logic               signed_q;
    logic               neg_quot_q;
    logic               neg_rem_q;
    logic               div_zero_q;

    // Datapath signals computed combinationally from the current state.
    logic [WIDTH:0]     rem_shift_d;
    logic [WIDTH:0]     trial_d;
    logic               qbit_d;
    logic [WIDTH-1:0]   mag1_d;
    logic [WIDTH-1:0]   mag2_d;
    logic [WIDTH-1:0]   quot_fix_d;
    logic [WIDTH-1:0]   rem_fix_d;

    // Trial subtraction, operand magnitudes and final sign correction.
    always_comb begin
        rem_shift_d = {prem_q, dvd_q[WIDTH-1]};
        trial_d     = rem_shift_d - {1'b0, dvs_q};
        qbit_d      = ~trial_d[WIDTH];

        // Magnitude of the most negative value stays 1000..0, which is the
        // correct unsigned magnitude, so no special case is needed.
        mag1_d = (M_div_signed && M_div_src1[WIDTH-1]) ? (~M_div_src1 + 1'b1) : M_div_src1;
        mag2_d = (M_div_signed && M_div_src2[WIDTH-1]) ? (~M_div_src2 + 1'b1) : M_div_src2;

        if (div_zero_q) begin
            quot_fix_d = '1;
            rem_fix_d  = src1_raw_q;
        end else begin
            quot_fix_d = (signed_q && neg_quot_q) ? (~dvd_q + 1'b1) : dvd_q;
            rem_fix_d  = (signed_q && neg_rem_q)  ? (~prem_q + 1'b1) : prem_q;
        end
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            quot_out_q <= '0;
            rem_out_q  <= '0;
            cnt_q      <= '0;
            dvd_q      <= '0;
            prem_q     <= '0;
            dvs_q      <= '0;
            src1_raw_q <= '0;
            signed_q   <= 1'b0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (M_div_start) begin
                        busy_q     <= 1'b1;
                        src1_raw_q <= M_div_src1;
                        signed_q   <= M_div_signed;
                        neg_quot_q <= M_div_src1[WIDTH-1] ^ M_div_src2[WIDTH-1];
                        neg_rem_q  <= M_div_src1[WIDTH-1];
                        dvd_q      <= mag1_d;
                        dvs_q      <= mag2_d;
                        prem_q     <= '0;
                        cnt_q      <= '0;
                        if (M_div_src2 == '0) begin
                            div_zero_q <= 1'b1;
                            state_q    <= S_FIXUP;
                        end else begin
                            div_zero_q <= 1'b0;
                            state_q    <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (qbit_d) begin
                        prem_q <= trial_d[WIDTH-1:0];
                    end else begin
                        prem_q <= rem_shift_d[WIDTH-1:0];
                    end
                    dvd_q <= {dvd_q[WIDTH-2:0], qbit_d};
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_q <= S_FIXUP;
                    end
                end
                S_FIXUP: begin
                    quot_out_q <= quot_fix_d;
                    rem_out_q  <= rem_fix_d;
                    done_q     <= 1'b1;
                    state_q    <= S_DONE;
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign M_div_busy      = busy_q;
    assign M_div_done      = done_q;
    assign M_div_quotient  = quot_out_q;
    assign M_div_remainder = rem_out_q;

endmodule

// File: tb/tb_unsaved_cpu_div_cell.sv
// Bench for unsaved_cpu_div_cell: directed corner cases plus random operands
// against an arithmetic reference, checking latency, handshake and results.
module tb_unsaved_cpu_div_cell;

    logic        clk;
    logic        reset_n;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        sgn;
    logic        start;
    logic        busy;
    logic        done;
    logic [31:0] quo;
    logic [31:0] rem;

    int n_tests;
    int n_fail;

    unsaved_cpu_div_cell #(.WIDTH(32), .CNT_W(6)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .M_div_src1      (src1),
        .M_div_src2      (src2),
        .M_div_signed    (sgn),
        .M_div_start     (start),
        .M_div_busy      (busy),
        .M_div_done      (done),
        .M_div_quotient  (quo),
        .M_div_remainder (rem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Truncating division semantics computed with 64-bit arithmetic.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                    output logic [31:0] q, output logic [31:0] r);
        longint sa, sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end
    endfunction

    // Runs one division starting at a negedge; returns at a negedge with the
    // block idle. repulse_at / rst_at (cycle index after acceptance, -1 = off)
    // inject a spurious start or an asynchronous reset mid-operation.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input int repulse_at, input int rst_at);
        logic [31:0] eq, er;
        int          cyc;
        int          exp_lat;
        bit          busy_ok;
        ref_div(a, b, s, eq, er);
        exp_lat = (b == 32'd0) ? 1 : 33;
        src1  = a;
        src2  = b;
        sgn   = s;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        src1  = $urandom;
        src2  = $urandom;
        sgn   = 1'($urandom_range(0, 1));
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        cyc     = 0;
        busy_ok = 1'b1;
        while (!done && cyc < 100) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (!busy) busy_ok = 1'b0;
            if (cyc == repulse_at) begin
                start = 1'b1;
                src1  = 32'd999;
                src2  = 32'd3;
                sgn   = 1'b0;
            end else begin
                start = 1'b0;
            end
            if (cyc == rst_at) begin
                reset_n = 1'b0;
                #1;
                check("rst_busy", {31'd0, busy}, 32'd0);
                check("rst_done", {31'd0, done}, 32'd0);
                check("rst_quo", quo, 32'd0);
                check("rst_rem", rem, 32'd0);
                @(negedge clk);
                reset_n = 1'b1;
                return;
            end
        end
        check("latency", 32'(cyc), 32'(exp_lat));
        check("done_pulse", {31'd0, done}, 32'd1);
        check("busy_in_done", {31'd0, busy}, 32'd1);
        check("busy_held", {31'd0, busy_ok}, 32'd1);
        check("quotient", quo, eq);
        check("remainder", rem, er);
        // A start during DONE must be dropped: busy must fall next cycle.
        start = 1'b1;
        src1  = 32'd77;
        src2  = 32'd0;
        sgn   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("done_cleared", {31'd0, done}, 32'd0);
        check("busy_cleared", {31'd0, busy}, 32'd0);
        check("quotient_held", quo, eq);
    endtask

    initial begin
        logic [31:0] a, b;
        logic        s;
        int          sel;
        n_tests = 0;
        n_fail  = 0;
        reset_n = 1'b0;
        src1    = '0;
        src2    = '0;
        sgn     = 1'b0;
        start   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_quo", quo, 32'd0);
        check("reset_rem", rem, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        run_op(32'd100, 32'd7, 1'b0, -1, -1);
        check("u100_7_q", quo, 32'd14);
        check("u100_7_r", rem, 32'd2);
        run_op(32'hFFFF_FF9C, 32'd7, 1'b1, -1, -1);
        check("sm100_7_q", quo, 32'hFFFF_FFF2);
        check("sm100_7_r", rem, 32'hFFFF_FFFE);
        run_op(32'd100, 32'hFFFF_FFF9, 1'b1, -1, -1);
        check("s100_m7_r", rem, 32'd2);
        run_op(32'h1234_5678, 32'd0, 1'b0, -1, -1);
        run_op(32'h1234_5678, 32'd0, 1'b1, -1, -1);
        check("dz_rem", rem, 32'h1234_5678);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, -1, -1);
        check("ovf_q", quo, 32'h8000_0000);
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, -1, -1);
        run_op(32'h8000_0000, 32'd3, 1'b1, -1, -1);
        run_op(32'd1000, 32'd3, 1'b0, 10, -1);
        check("repulse_q", quo, 32'd333);
        run_op(32'd12345, 32'd17, 1'b0, -1, -1);
        run_op(32'd100, 32'd7, 1'b0, -1, 15);
        run_op(32'd50, 32'd5, 1'b0, -1, -1);
        check("post_rst_q", quo, 32'd10);
        check("post_rst_r", rem, 32'd0);

        for (int i = 0; i < 40; i++) begin
            a   = $urandom;
            s   = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 9);
            if (sel == 0) begin
                b = 32'd0;
            end else if (sel < 5) begin
                b = 32'($urandom_range(1, 20));
                if (s && $urandom_range(0, 1) == 1) b = -b;
            end else begin
                b = $urandom;
                if (sel == 9) a = a >> $urandom_range(0, 31);
            end
            run_op(a, b, s, -1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
